// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam logic [7:0] TAG_PREFIX = 8'hA0;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

    // Beat counter must be able to hold MAX_BURST itself.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotated priority encoder: first set request at or above rr_ptr, wrapping.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] index
);

    localparam int unsigned IW = idx_width(NUM_REQ);

    // Scan farthest offset first so the nearest candidate overwrites it.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (req[(32'(rr_ptr) + k - 1) % NUM_REQ]) begin
                found = 1'b1;
                index = IW'((32'(rr_ptr) + k - 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Burst-granular round-robin arbiter for the UART TX FIFO write port.
// Define UART_ARB_TAG_EN to prefix every grant with a TAG_PREFIX|grant_id header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_wr_en,
    output logic [7:0]                   tx_wr_data,
    input  logic                         tx_full,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int unsigned IW = idx_width(NUM_REQ);
    localparam int unsigned BW = cnt_width(MAX_BURST);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] beat_cnt;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          beat;
    logic          burst_end;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    assign beat      = (state == XFER) && req_valid[grant_id] && !tx_full;
    assign burst_end = beat && (req_last[grant_id] || (beat_cnt == BW'(MAX_BURST - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_found) begin
`ifdef UART_ARB_TAG_EN
                    state_nxt = HDR;
`else
                    state_nxt = XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            HDR: begin
                if (!tx_full) begin
                    state_nxt = XFER;
                end
            end
`endif
            XFER: begin
                if (burst_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO write port is a zero-latency pass-through of the granted requester.
    always_comb begin
        req_ready  = '0;
        tx_wr_en   = 1'b0;
        tx_wr_data = 8'h00;
        case (state)
`ifdef UART_ARB_TAG_EN
            HDR: begin
                if (!tx_full) begin
                    tx_wr_en   = 1'b1;
                    tx_wr_data = TAG_PREFIX | 8'(grant_id);
                end
            end
`endif
            XFER: begin
                req_ready[grant_id] = !tx_full;
                if (beat) begin
                    tx_wr_en   = 1'b1;
                    tx_wr_data = req_data[32'(grant_id) * 8 +: 8];
                end
            end
            default: ;
        endcase
    end

    // Grant bookkeeping; grant_id is retained in IDLE until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                    end
                end
                XFER: begin
                    if (burst_end) begin
                        beat_cnt <= '0;
                        busy     <= 1'b0;
                        rr_ptr   <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
